hmac_stream_engine: RTL and testbench

HMAC_STREAM_ENGINE -- requirements
Module: hmac_stream_engine

---
 rtl/hmac_stream_engine.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_hmac_stream_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hmac_stream_engine.sv
// HMAC-SHA256 streaming engine: hashes (K0^ipad)||M, then (K0^opad)||inner,
// over a shared iterative SHA-256 core that processes one round per cycle.

module sha256_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         next_block,
    input  logic [511:0] block_in,
    output logic [255:0] hash_out,
    output logic         ready
);
    localparam logic [2047:0] K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [255:0] h_q, work_q, work_d, h_sum;
    logic [511:0] w_q, w_d;
    logic [5:0]   round_q;
    logic         busy_q;
    logic [31:0]  wa, wb, wc, wd, we, wf, wg, wh, t1, t2, kt, w_new;

    always_comb begin
        {wa, wb, wc, wd, we, wf, wg, wh} = work_q;
        kt    = K_TABLE[{~round_q, 5'd0} +: 32];
        t1    = wh + (rotr(we, 6) ^ rotr(we, 11) ^ rotr(we, 25)) + ((we & wf) ^ (~we & wg))
              + kt + w_q[511:480];
        t2    = (rotr(wa, 2) ^ rotr(wa, 13) ^ rotr(wa, 22)) + ((wa & wb) ^ (wa & wc) ^ (wb & wc));
        work_d = {t1 + t2, wa, wb, wc, wd + t1, we, wf, wg};
        // Sliding 16-word schedule window: word t sits at the top.
        w_new = (rotr(w_q[63:32], 17) ^ rotr(w_q[63:32], 19) ^ (w_q[63:32] >> 10)) + w_q[223:192]
              + (rotr(w_q[479:448], 7) ^ rotr(w_q[479:448], 18) ^ (w_q[479:448] >> 3)) + w_q[511:480];
        w_d   = {w_q[479:0], w_new};
        for (int i = 0; i < 8; i++) begin
            h_sum[i*32 +: 32] = h_q[i*32 +: 32] + work_d[i*32 +: 32];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            work_q  <= '0;
            w_q     <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
        end else if (busy_q) begin
            work_q  <= work_d;
            w_q     <= w_d;
            round_q <= round_q + 6'd1;
            if (round_q == 6'd63) begin
                h_q    <= h_sum;
                busy_q <= 1'b0;
            end
        end else begin
            if (init) h_q <= IV;
            if (next_block) begin
                work_q  <= h_q;
                w_q     <= block_in;
                round_q <= '0;
                busy_q  <= 1'b1;
            end
        end
    end

    assign hash_out = h_q;
    assign ready    = ~busy_q;
endmodule

module hmac_stream_engine #(
    parameter int KEY_BYTES = 32,
    parameter int LEN_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   abort,
    input  logic [KEY_BYTES*8-1:0] key,
    input  logic [LEN_W-1:0]       msg_len,
    input  logic [255:0]           expected_mac,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [31:0]            s_data,
    output logic [255:0]           mac_out,
    output logic                   busy,
    output logic                   done,
    output logic                   match,
    output logic                   aborted
);
    typedef enum logic [3:0] {IDLE, IKEY, MSG, PAD1, PAD2, OKEY, OFIN, WAIT_O, FIN} state_t;

    localparam logic [511:0] IPAD = {64{8'h36}};
    localparam logic [511:0] OPAD = {64{8'h5c}};

    state_t                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [KEY_BYTES*8-1:0] key_q, key_d;
    logic [LEN_W-1:0]       len_q, len_d, acc_q, acc_d, remaining;
    logic [255:0]           exp_q, exp_d, inner_q, inner_d, mac_q, mac_d;
    logic [511:0]           buf_q, buf_d, blk_q, blk_d, blk_sel, k0, pad1_blk;
    logic [6:0]             fill_q, fill_d;
    logic                   step_q, step_d, hashing_q, hashing_d;
    logic                   match_q, match_d, done_q, done_d, aborted_q, aborted_d;
    logic                   sha_init, sha_next, sha_ready, xfer, pad_two;
    logic [255:0]           sha_hash;
    logic [63:0]            bit_len;
    logic [2:0]             nbytes;
    logic [31:0]            byte_mask;
    logic [8:0]             word_shift, tail_shift;

    sha256_core u_sha (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (sha_init),
        .next_block (sha_next),
        .block_in   (blk_d),
        .hash_out   (sha_hash),
        .ready      (sha_ready)
    );

    assign k0         = 512'(key_q) << ((64 - KEY_BYTES) * 8);
    assign bit_len    = (64'(len_q) + 64'd64) << 3;
    assign pad_two    = len_q[5:0] >= 6'd56;
    assign tail_shift = {6'd63 - len_q[5:0], 3'b000};
    assign pad1_blk   = buf_q | (512'h80 << tail_shift) | (pad_two ? 512'd0 : {448'd0, bit_len});

    assign remaining  = len_q - acc_q;
    assign nbytes     = (remaining >= LEN_W'(4)) ? 3'd4 : remaining[2:0];
    assign byte_mask  = 32'hffff_ffff << {3'd4 - nbytes, 3'b000};
    assign word_shift = {4'd15 - fill_q[5:2], 5'd0};

    assign s_ready = (state_q == MSG) && (fill_q != 7'd64) && !hashing_q && (acc_q < len_q);
    assign xfer    = s_valid && s_ready;

    always_comb begin
        case (state_q)
            IKEY:         blk_sel = k0 ^ IPAD;
            PAD1:         blk_sel = pad1_blk;
            PAD2:         blk_sel = {448'd0, bit_len};
            OKEY:         blk_sel = k0 ^ OPAD;
            OFIN, WAIT_O: blk_sel = {inner_q, 8'h80, 184'd0, 64'd768};
            default:      blk_sel = buf_q;
        endcase
        // The core sees a block that stays frozen from its next_block pulse until the following one.
        blk_d = sha_next ? blk_sel : blk_q;
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        key_d     = key_q;
        len_d     = len_q;
        exp_d     = exp_q;
        acc_d     = acc_q;
        buf_d     = buf_q;
        fill_d    = fill_q;
        step_d    = step_q;
        hashing_d = hashing_q;
        inner_d   = inner_q;
        mac_d     = mac_q;
        match_d   = match_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        sha_init  = 1'b0;
        sha_next  = 1'b0;

        case (state_q)
            IDLE: if (start && !abort) begin
                mode_d    = mode;
                key_d     = key;
                len_d     = msg_len;
                exp_d     = expected_mac;
                acc_d     = '0;
                buf_d     = '0;
                fill_d    = '0;
                step_d    = 1'b0;
                hashing_d = 1'b0;
                state_d   = IKEY;
            end
            IKEY: if (sha_ready) begin
                if (!step_q) begin
                    sha_init = 1'b1;
                    step_d   = 1'b1;
                end else begin
                    sha_next = 1'b1;
                    step_d   = 1'b0;
                    state_d  = MSG;
                end
            end
            MSG: begin
                if (xfer) begin
                    buf_d  = buf_q | ({480'd0, s_data & byte_mask} << word_shift);
                    fill_d = fill_q + 7'(nbytes);
                    acc_d  = acc_q + LEN_W'(nbytes);
                end
                if (hashing_q) begin
                    if (sha_ready) begin
                        hashing_d = 1'b0;
                        buf_d     = '0;
                        fill_d    = '0;
                    end
                end else if (fill_q == 7'd64) begin
                    if (sha_ready) begin
                        sha_next  = 1'b1;
                        hashing_d = 1'b1;
                    end
                end else if (acc_q == len_q) begin
                    state_d = PAD1;
                end
            end
            PAD1, PAD2: if (sha_ready) begin
                if (!step_q) begin
                    sha_next = 1'b1;
                    step_d   = 1'b1;
                end else begin
                    step_d  = 1'b0;
                    state_d = (state_q == PAD1 && pad_two) ? PAD2 : OKEY;
                end
            end
            OKEY: if (sha_ready) begin
                if (!step_q) begin
                    inner_d  = sha_hash;
                    sha_init = 1'b1;
                    step_d   = 1'b1;
                end else begin
                    sha_next = 1'b1;
                    step_d   = 1'b0;
                    state_d  = OFIN;
                end
            end
            OFIN: if (sha_ready) begin
                sha_next = 1'b1;
                state_d  = WAIT_O;
            end
            WAIT_O: if (sha_ready) state_d = FIN;
            FIN: begin
                mac_d   = sha_hash;
                // Full-width XOR reduction keeps the compare time independent of where bits differ.
                match_d = mode_q & ~(|(sha_hash ^ exp_q));
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
            done_d    = 1'b0;
            mac_d     = mac_q;
            match_d   = match_q;
            sha_init  = 1'b0;
            sha_next  = 1'b0;
            step_d    = 1'b0;
            hashing_d = 1'b0;
        end
    end

    // NOTE: the block buffer and block latch are ordinary flops, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            key_q     <= '0;
            len_q     <= '0;
            exp_q     <= '0;
            acc_q     <= '0;
            buf_q     <= '0;
            blk_q     <= '0;
            fill_q    <= '0;
            step_q    <= 1'b0;
            hashing_q <= 1'b0;
            inner_q   <= '0;
            mac_q     <= '0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            key_q     <= key_d;
            len_q     <= len_d;
            exp_q     <= exp_d;
            acc_q     <= acc_d;
            buf_q     <= buf_d;
            blk_q     <= blk_d;
            fill_q    <= fill_d;
            step_q    <= step_d;
            hashing_q <= hashing_d;
            inner_q   <= inner_d;
            mac_q     <= mac_d;
            match_q   <= match_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign aborted = aborted_q;
    assign match   = match_q;
    assign mac_out = mac_q;
endmodule

// File: tb/tb_hmac_stream_engine.sv
// Self-checking bench for hmac_stream_engine: known HMAC vectors, random lengths
// against a queue-based HMAC-SHA256 model, verify mode, abort and mid-run reset.

module tb_hmac_stream_engine;
    localparam int BUDGET = 5000;
    localparam logic [255:0] TC1_MAC = 256'hb0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7;
    localparam logic [255:0] TC2_MAC = 256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843;
    localparam logic [159:0] KEY1    = {20{8'h0b}};
    localparam logic [159:0] KEY2    = {"Jefe", 128'h0};
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef logic [7:0] bytes_t [$];

    logic         clk = 1'b0;
    logic         rst_n, start, mode, abort, s_valid;
    logic [159:0] key;
    logic [31:0]  msg_len, s_data;
    logic [255:0] expected_mac, mac_out;
    logic         s_ready, busy, done, match, aborted;

    logic [7:0]   msg_mem [0:255];
    int           n_checks = 0;
    int           n_pass   = 0;

    hmac_stream_engine #(.KEY_BYTES(20), .LEN_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .abort        (abort),
        .key          (key),
        .msg_len      (msg_len),
        .expected_mac (expected_mac),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .mac_out      (mac_out),
        .busy         (busy),
        .done         (done),
        .match        (match),
        .aborted      (aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_ref(input bytes_t m);
        bytes_t          p;
        logic [31:0]     h [8];
        logic [31:0]     w [64];
        logic [31:0]     a, b, c, d, e, f, g, hh, t1, t2;
        longint unsigned nbits;
        p = m;
        nbits = longint'(m.size()) * 8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(nbits >> (8 * i)));
        h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int blk = 0; blk < p.size() / 64; blk++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {p[blk*64 + 4*t], p[blk*64 + 4*t + 1], p[blk*64 + 4*t + 2], p[blk*64 + 4*t + 3]};
            for (int t = 16; t < 64; t++)
                w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            {a, b, c, d, e, f, g, hh} = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
                t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d;
            h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    function automatic logic [255:0] hmac_ref(input logic [159:0] k, input int len);
        bytes_t       inner, outer;
        logic [7:0]   kb;
        logic [255:0] ih;
        for (int i = 0; i < 64; i++) begin
            kb = (i < 20) ? k[159 - 8*i -: 8] : 8'h00;
            inner.push_back(kb ^ 8'h36);
            outer.push_back(kb ^ 8'h5c);
        end
        for (int i = 0; i < len; i++) inner.push_back(msg_mem[i]);
        ih = sha_ref(inner);
        for (int i = 0; i < 32; i++) outer.push_back(ih[255 - 8*i -: 8]);
        return sha_ref(outer);
    endfunction

    // Bytes past the message end are filled with noise; the engine must discard them.
    function automatic logic [31:0] word_at(input int widx, input int len);
        logic [31:0] wv;
        for (int j = 0; j < 4; j++)
            wv[31 - 8*j -: 8] = (4*widx + j < len) ? msg_mem[4*widx + j] : 8'($urandom);
        return wv;
    endfunction

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) msg_mem[i] = s[i];
    endtask

    task automatic load_random(input int len);
        for (int i = 0; i < len; i++) msg_mem[i] = 8'($urandom);
    endtask

    task automatic run_op(input logic m, input logic [159:0] k, input int len, input logic [255:0] exp,
                          input int gap_pct, input int abort_at,
                          output int cycles, output int nblk, output bit got_done, output bit got_abort);
        int nwords, widx;
        bit abort_sent;
        nwords = (len + 3) / 4;
        widx = 0; nblk = 0; cycles = 0; got_done = 0; got_abort = 0; abort_sent = 0;
        @(negedge clk);
        mode = m; key = k; msg_len = len; expected_mac = exp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        for (int c = 0; c < BUDGET; c++) begin
            if (done)    begin got_done  = 1; break; end
            if (aborted) begin got_abort = 1; break; end
            abort = (abort_at >= 0) && !abort_sent && (widx == abort_at);
            if (abort) abort_sent = 1;
            if (!abort && widx < nwords && $urandom_range(99) >= gap_pct) begin
                s_valid = 1'b1;
                s_data  = word_at(widx, len);
            end else begin
                s_valid = 1'b0;
                s_data  = $urandom;
            end
            #1;
            if (dut.sha_next) nblk++;
            if (s_valid && s_ready) widx++;
            @(negedge clk);
            cycles++;
        end
        s_valid = 1'b0;
        abort   = 1'b0;
    endtask

    initial begin
        int           cyc_a, cyc_b, nblk, exp_blk;
        bit           got_done, got_abort;
        logic [159:0] rkey;
        logic [255:0] prev_mac;
        logic         prev_match;
        int           lens [7] = '{0, 55, 56, 63, 64, 65, 130};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; s_valid = 1'b0;
        key = '0; msg_len = '0; s_data = '0; expected_mac = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",    busy,    0);
        check("rst_done",    done,    0);
        check("rst_aborted", aborted, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_match",   match,   0);
        check("rst_mac",     mac_out, 0);
        rst_n = 1'b1;

        load_str("Hi There");
        run_op(0, KEY1, 8, '0, 30, -1, cyc_a, nblk, got_done, got_abort);
        check("tc1_done",      got_done, 1);
        check("tc1_mac",       mac_out,  TC1_MAC);
        check("tc1_match_gen", match,    0);

        load_str("what do ya want for nothing?");
        run_op(0, KEY2, 28, '0, 30, -1, cyc_a, nblk, got_done, got_abort);
        check("tc2_mac", mac_out, TC2_MAC);

        run_op(1, KEY2, 28, TC2_MAC, 0, -1, cyc_a, nblk, got_done, got_abort);
        check("verify_ok_done",  got_done, 1);
        check("verify_ok_match", match,    1);
        run_op(1, KEY2, 28, TC2_MAC ^ (256'd1 << 77), 0, -1, cyc_b, nblk, got_done, got_abort);
        check("verify_bad_match",   match,   0);
        check("verify_bad_mac",     mac_out, TC2_MAC);
        check("verify_same_cycles", 256'(cyc_b), 256'(cyc_a));

        foreach (lens[i]) begin
            rkey = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            load_random(lens[i]);
            run_op(0, rkey, lens[i], '0, 40, -1, cyc_a, nblk, got_done, got_abort);
            exp_blk = 1 + lens[i] / 64 + (((lens[i] % 64) >= 56) ? 2 : 1) + 2;
            check($sformatf("len%0d_mac", lens[i]),    mac_out,     hmac_ref(rkey, lens[i]));
            check($sformatf("len%0d_blocks", lens[i]), 256'(nblk), 256'(exp_blk));
        end

        rkey = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        load_random(64);
        run_op(0, rkey, 64, '0, 0, -1, cyc_a, nblk, got_done, got_abort);
        rkey = ~rkey;
        load_random(64);
        run_op(1, rkey, 64, '0, 0, -1, cyc_b, nblk, got_done, got_abort);
        check("latency_data_independent", 256'(cyc_b), 256'(cyc_a));

        prev_mac   = mac_out;
        prev_match = match;
        load_random(40);
        run_op(0, rkey, 40, '0, 0, 3, cyc_a, nblk, got_done, got_abort);
        check("abort_pulse",     got_abort, 1);
        check("abort_no_done",   got_done,  0);
        check("abort_busy",      busy,      0);
        check("abort_s_ready",   s_ready,   0);
        check("abort_mac_held",  mac_out,   prev_mac);
        check("abort_match_held", match,    prev_match);
        load_str("Hi There");
        run_op(0, KEY1, 8, '0, 20, -1, cyc_a, nblk, got_done, got_abort);
        check("post_abort_mac", mac_out, TC1_MAC);

        @(negedge clk);
        mode = 1'b1; key = KEY1; msg_len = 8; expected_mac = TC1_MAC; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_busy",    busy,    0);
        check("midrun_rst_s_ready", s_ready, 0);
        check("midrun_rst_done",    done,    0);
        check("midrun_rst_aborted", aborted, 0);
        check("midrun_rst_match",   match,   0);
        check("midrun_rst_mac",     mac_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1, KEY1, 8, TC1_MAC, 25, -1, cyc_a, nblk, got_done, got_abort);
        check("post_reset_mac",   mac_out, TC1_MAC);
        check("post_reset_match", match,   1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
